rand_pulse_scheduler: RTL and testbench

//   Sequences the random pulse generator: bursts of pulses with random gaps.
//   A Galois LFSR draws gaps as min_gap + (LFSR & gap_mask).

---
 rtl/rand_pulse_scheduler_if.sv | 34 +++
 rtl/rand_pulse_scheduler.sv | 146 ++++++++++++++
 tb/tb_rand_pulse_scheduler.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rand_pulse_scheduler_if.sv
// Control/status bundle for rand_pulse_scheduler.
// The master drives run configuration and commands; the slave is the scheduler itself.
interface rand_pulse_scheduler_if #(
  parameter int LFSR_W  = 16,
  parameter int CNT_W   = 16,
  parameter int WIDTH_W = 8,
  parameter int BURST_W = 8
);
  logic               start;
  logic               stop;
  logic               seed_load;
  logic [LFSR_W-1:0]  seed;
  logic [CNT_W-1:0]   min_gap;
  logic [CNT_W-1:0]   gap_mask;
  logic [WIDTH_W-1:0] pulse_width;
  logic [BURST_W-1:0] burst_len;
  logic               irq_clr;
  logic               pulse_out;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] pulse_cnt;
  logic [LFSR_W-1:0]  lfsr_state;
  logic               irq;

  modport master (
    output start, stop, seed_load, seed, min_gap, gap_mask, pulse_width, burst_len, irq_clr,
    input  pulse_out, busy, done, pulse_cnt, lfsr_state, irq
  );

  modport slave (
    input  start, stop, seed_load, seed, min_gap, gap_mask, pulse_width, burst_len, irq_clr,
    output pulse_out, busy, done, pulse_cnt, lfsr_state, irq
  );
endinterface

// File: rtl/rand_pulse_scheduler.sv
// Burst pulse scheduler with LFSR-randomised gaps between pulses.
// Optional sticky burst-done interrupt enabled by defining RPS_IRQ_EN.
module rand_pulse_scheduler #(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
  parameter int                CNT_W     = 16,
  parameter int                WIDTH_W   = 8,
  parameter int                BURST_W   = 8
) (
  input logic clk,
  input logic rst,
  rand_pulse_scheduler_if.slave bus
);
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(16'hACE1);

  typedef enum logic [1:0] {IDLE, GAP, PULSE, DONE} state_t;

  state_t             state;
  logic               pulse_out_q;
  logic               busy_q;
  logic               done_q;
  logic [BURST_W-1:0] pulse_cnt_q;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [CNT_W-1:0]   gap_cnt;
  logic [WIDTH_W-1:0] width_cnt;
  logic [CNT_W-1:0]   min_gap_q;
  logic [CNT_W-1:0]   gap_mask_q;
  logic [WIDTH_W-1:0] width_m1_q;
  logic [BURST_W-1:0] burst_q;

  logic [LFSR_W-1:0]  seed_eff;
  logic [LFSR_W-1:0]  draw_src;
  logic [LFSR_W-1:0]  lfsr_next;
  logic [CNT_W-1:0]   use_min;
  logic [CNT_W-1:0]   use_mask;
  logic [CNT_W:0]     gap_sum;
  logic [CNT_W-1:0]   gap_val;
  logic [BURST_W-1:0] cnt_inc;

  // In IDLE the draw uses live config (and a same-cycle seed); during a run the shadows.
  always_comb begin
    seed_eff  = (bus.seed == '0) ? SEED_DEFAULT : bus.seed;
    draw_src  = (state == IDLE && bus.seed_load) ? seed_eff : lfsr_q;
    lfsr_next = (draw_src >> 1) ^ (draw_src[0] ? LFSR_TAPS : '0);
    use_min   = (state == IDLE) ? bus.min_gap  : min_gap_q;
    use_mask  = (state == IDLE) ? bus.gap_mask : gap_mask_q;
    gap_sum   = {1'b0, use_min} + {1'b0, lfsr_next[CNT_W-1:0] & use_mask};
    gap_val   = gap_sum[CNT_W] ? '1 : gap_sum[CNT_W-1:0];
    cnt_inc   = pulse_cnt_q + BURST_W'(1);
  end

  // Counters hold the remaining cycles minus one, so zero marks the last cycle of a phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pulse_cnt_q <= '0;
      lfsr_q      <= SEED_DEFAULT;
      gap_cnt     <= '0;
      width_cnt   <= '0;
      min_gap_q   <= '0;
      gap_mask_q  <= '0;
      width_m1_q  <= '0;
      burst_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.seed_load) lfsr_q <= seed_eff;
          if (bus.start && !bus.stop) begin
            min_gap_q   <= bus.min_gap;
            gap_mask_q  <= bus.gap_mask;
            width_m1_q  <= (bus.pulse_width == '0) ? '0 : bus.pulse_width - WIDTH_W'(1);
            burst_q     <= bus.burst_len;
            pulse_cnt_q <= '0;
            lfsr_q      <= lfsr_next;
            gap_cnt     <= gap_val;
            busy_q      <= 1'b1;
            state       <= GAP;
          end
        end
        GAP: begin
          if (bus.stop) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (gap_cnt == '0) begin
            state       <= PULSE;
            pulse_out_q <= 1'b1;
            width_cnt   <= width_m1_q;
          end else begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end
        end
        PULSE: begin
          if (bus.stop) begin
            state       <= IDLE;
            pulse_out_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (width_cnt != '0) begin
            width_cnt <= width_cnt - WIDTH_W'(1);
          end else begin
            pulse_out_q <= 1'b0;
            pulse_cnt_q <= cnt_inc;
            if (burst_q != '0 && cnt_inc == burst_q) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              lfsr_q  <= lfsr_next;
              gap_cnt <= gap_val;
              state   <= GAP;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pulse_out  = pulse_out_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pulse_cnt  = pulse_cnt_q;
  assign bus.lfsr_state = lfsr_q;

`ifdef RPS_IRQ_EN
  logic irq_q;

  // Set is taken from the done strobe itself, so a clear during that cycle loses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= done_q | (irq_q & ~bus.irq_clr);
  end

  assign bus.irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = bus.irq_clr;
  assign bus.irq        = 1'b0;
`endif
endmodule

// File: tb/tb_rand_pulse_scheduler.sv
// Directed self-checking bench for rand_pulse_scheduler.
// Inputs change and outputs are sampled on the falling edge; cycle k is the value visible after rising edge k-1.
module tb_rand_pulse_scheduler;
`ifdef RPS_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rand_pulse_scheduler_if bus ();

  rand_pulse_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [15:0] mg, input logic [15:0] mk,
                                input logic [7:0] w, input logic [7:0] b);
    bus.min_gap     = mg;
    bus.gap_mask    = mk;
    bus.pulse_width = w;
    bus.burst_len   = b;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed      = '0;
    bus.irq_clr   = 1'b0;
    apply_stimulus(16'd0, 16'd0, 8'd0, 8'd0);

    // Reset values
    #2 rst = 1'b1;
    #2;
    check("rst_lfsr", bus.lfsr_state, 32'hACE1);
    check("rst_pulse", bus.pulse_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cnt", bus.pulse_cnt, 0);
    check("rst_irq", bus.irq, 0);
    @(negedge clk);
    rst = 1'b0;

    // Two-pulse burst with fixed gap of 3
    apply_stimulus(16'd3, 16'd0, 8'd2, 8'd2);
    bus.start = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      bus.start = 1'b0;
      check($sformatf("t2_pulse_c%0d", k), bus.pulse_out,
            (k == 5 || k == 6 || k == 11 || k == 12) ? 1 : 0);
      check($sformatf("t2_done_c%0d", k), bus.done, (k == 13) ? 1 : 0);
      check($sformatf("t2_busy_c%0d", k), bus.busy, (k <= 13) ? 1 : 0);
    end
    check("t2_cnt", bus.pulse_cnt, 2);
    check("t2_irq_set", bus.irq, IRQ_ON);
    bus.irq_clr = 1'b1;
    tick();
    bus.irq_clr = 1'b0;
    check("t2_irq_clr", bus.irq, 0);

    // Asynchronous reset in the middle of a pulse
    bus.start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      bus.start = 1'b0;
    end
    check("mid_pulse_hi", bus.pulse_out, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_pulse", bus.pulse_out, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_lfsr", bus.lfsr_state, 32'hACE1);
    @(negedge clk);
    rst = 1'b0;

    // First draw from the default seed; seed_load while busy is ignored
    apply_stimulus(16'd5, 16'h0003, 8'd1, 8'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t3_lfsr_draw", bus.lfsr_state, 32'hE270);
    bus.seed_load = 1'b1;
    bus.seed      = 16'h1234;
    tick();
    bus.seed_load = 1'b0;
    check("t3_seed_busy", bus.lfsr_state, 32'hE270);
    repeat (4) tick();
    check("t3_gap_end", bus.pulse_out, 0);
    tick();
    check("t3_pulse", bus.pulse_out, 1);
    tick();
    check("t3_done", bus.done, 1);
    check("t3_cnt", bus.pulse_cnt, 1);
    tick();
    check("t3_idle", bus.busy, 0);
    check("t3_lfsr_hold", bus.lfsr_state, 32'hE270);

    // Seed loading in IDLE, zero substitution, load+start, stop in GAP, stop blocking start
    bus.irq_clr   = 1'b1;
    bus.seed_load = 1'b1;
    bus.seed      = 16'h5555;
    tick();
    bus.irq_clr   = 1'b0;
    check("t4_seed", bus.lfsr_state, 32'h5555);
    bus.seed = 16'h0000;
    tick();
    check("t4_seed_zero", bus.lfsr_state, 32'hACE1);
    bus.seed = 16'h0001;
    apply_stimulus(16'd0, 16'hFFFF, 8'd1, 8'd0);
    bus.start = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.seed_load = 1'b0;
    check("t4_load_start", bus.lfsr_state, 32'hB400);
    bus.stop = 1'b1;
    tick();
    check("t4_stop_busy", bus.busy, 0);
    check("t4_stop_done", bus.done, 0);
    check("t4_stop_lfsr", bus.lfsr_state, 32'hB400);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("t4_stop_blocks", bus.busy, 0);

    // Continuous mode, zero width and gap: alternating single-cycle pulses
    apply_stimulus(16'd0, 16'd0, 8'd0, 8'd0);
    bus.start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      bus.start = 1'b0;
      check($sformatf("t5_pulse_c%0d", k), bus.pulse_out, (k % 2 == 0) ? 1 : 0);
    end
    check("t5_cnt", bus.pulse_cnt, 3);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("t5_stop_pulse", bus.pulse_out, 0);
    check("t5_stop_busy", bus.busy, 0);
    check("t5_stop_cnt", bus.pulse_cnt, 3);
    tick();
    check("t5_no_done", bus.done, 0);

    // Pulse counter wraps after 256 pulses in continuous mode
    bus.start = 1'b1;
    for (int k = 1; k <= 514; k++) begin
      tick();
      bus.start = 1'b0;
    end
    check("wrap_cnt", bus.pulse_cnt, 0);
    check("wrap_pulse", bus.pulse_out, 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // Sticky interrupt: clear on the done cycle loses to the set
    apply_stimulus(16'd0, 16'd0, 8'd1, 8'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("t6_irq_pre", bus.irq, 0);
    tick();
    check("t6_done", bus.done, 1);
    bus.irq_clr = 1'b1;
    tick();
    bus.irq_clr = 1'b0;
    check("t6_irq_set_wins", bus.irq, IRQ_ON);
    tick();
    check("t6_irq_sticky", bus.irq, IRQ_ON);
    bus.irq_clr = 1'b1;
    tick();
    bus.irq_clr = 1'b0;
    check("t6_irq_cleared", bus.irq, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
